// File: rtl/boot_memory.sv
// boot_memory: byte-wide unified instruction/data memory for the 8-bit
// multicycle MIPS core. A program image (length header + bytes) is streamed
// in over a valid/ready port while the core is held in reset. Once the image
// is complete the core is released and served with zero-latency reads.
module boot_memory #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] memdata,
  output logic              cpu_reset,
  output logic              loading
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    LOAD_HDR  = 2'd0,
    LOAD_DATA = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] load_adr, load_adr_nx;
  logic              hs;
  logic              load_we;
  logic              run_we;
  logic              memread_unused;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reads are always combinational, so the core's read strobe carries no
  // information for this block.
  assign memread_unused = memread;

  // in_ready depends on state only, never on in_valid.
  assign in_ready = (state != RUN);
  assign hs       = in_valid & in_ready;
  assign load_we  = (state == LOAD_DATA) & in_valid;
  assign run_we   = (state == RUN) & memwrite;

  // The core only sees memory contents once it is running.
  assign memdata  = (state == RUN) ? mem[adr] : '0;

  // Next-state logic: header captures the byte count, data phase counts
  // bytes up to the header value. A header of 0 yields a full 2**ADDR_W
  // image because cnt-1 wraps to the last address.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    load_adr_nx = load_adr;
    case (state)
      LOAD_HDR: begin
        if (hs) begin
          cnt_nx      = ADDR_W'(in_data);
          load_adr_nx = '0;
          state_nx    = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        if (hs) begin
          load_adr_nx = load_adr + ADDR_W'(1);
          if (load_adr == cnt - ADDR_W'(1)) state_nx = RUN;
        end
      end
      RUN: begin
        if (reload) state_nx = LOAD_HDR;
      end
      default: state_nx = LOAD_HDR;
    endcase
  end

  // State and load bookkeeping; cpu_reset/loading follow next-state so they
  // change on the same edge the state does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD_HDR;
      cnt       <= '0;
      load_adr  <= '0;
      cpu_reset <= 1'b1;
      loading   <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      load_adr  <= load_adr_nx;
      cpu_reset <= (state_nx != RUN);
      loading   <= (state_nx != RUN);
    end
  end

  // Memory array is deliberately not reset so an image survives a reset.
  // Load writes and core writes are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_adr] <= in_data;
    else if (run_we) mem[adr] <= writedata;
  end

endmodule

// File: tb/tb_boot_memory.sv
// Scoreboard bench for boot_memory: stimulus pushes expected outputs and
// raises memread as a probe strobe; a monitor pops and compares on negedge.
module tb_boot_memory;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       reload;
  logic       memread;
  logic       memwrite;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic [7:0] memdata;
  logic       cpu_reset;
  logic       loading;

  int checks   = 0;
  int failures = 0;

  string      nq[$];
  logic [10:0] eq[$];

  boot_memory #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .memread(memread),
    .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .memdata(memdata), .cpu_reset(cpu_reset), .loading(loading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: whenever a probe is raised, compare against the oldest expectation.
  initial begin
    string       nm;
    logic [10:0] ex;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      if (memread) begin
        checks++;
        act = {memdata, cpu_reset, loading, in_ready};
        if (eq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_probe: got md=%h cr=%b ld=%b rdy=%b with empty scoreboard",
                   memdata, cpu_reset, loading, in_ready);
        end else begin
          nm = nq.pop_front();
          ex = eq.pop_front();
          if (act !== ex) begin
            failures++;
            $display("FAIL %s: got md=%h cr=%b ld=%b rdy=%b, want md=%h cr=%b ld=%b rdy=%b",
                     nm, act[10:3], act[2], act[1], act[0],
                     ex[10:3], ex[2], ex[1], ex[0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    memread = 1'b0;
  endtask

  task automatic probe(input string nm, input logic [7:0] md,
                       input logic cr, input logic ld, input logic rdy);
    nq.push_back(nm);
    eq.push_back({md, cr, ld, rdy});
    memread = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [7:0] a, input logic [7:0] md);
    adr = a;
    probe(nm, md, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    logic [7:0] b;
    reset = 1'b1; in_data = '0; in_valid = 1'b0; reload = 1'b0;
    memread = 1'b0; memwrite = 1'b0; adr = '0; writedata = '0;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state, basic 3-byte image
    probe("t1_reset", 8'h00, 1'b1, 1'b1, 1'b1);
    tick();
    send(8'd3); send(8'hAA); send(8'hBB);
    in_valid = 1'b1; in_data = 8'hCC;
    probe("t1_last_byte", 8'h00, 1'b1, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    rd("t1_a0", 8'd0, 8'hAA);
    rd("t1_a1", 8'd1, 8'hBB);
    rd("t1_a2", 8'd2, 8'hCC);

    // 2: gapped stream, held bytes must not be written
    reload = 1'b1; tick(); reload = 1'b0;
    probe("t2_reloaded", 8'h00, 1'b1, 1'b1, 1'b1);
    tick();
    send(8'd2);
    in_data = 8'h99; probe("t2_gap", 8'h00, 1'b1, 1'b1, 1'b1); tick();
    send(8'h11);
    in_data = 8'h55; tick();
    send(8'h22);
    rd("t2_a0", 8'd0, 8'h11);
    rd("t2_a1", 8'd1, 8'h22);
    rd("t2_a2_kept", 8'd2, 8'hCC);

    // 3: core write, read-old-during-write
    adr = 8'h40; memwrite = 1'b1; writedata = 8'h33; tick();
    writedata = 8'h5A;
    probe("t3_old_value", 8'h33, 1'b0, 1'b0, 1'b0);
    tick();
    memwrite = 1'b0;
    rd("t3_new_value", 8'h40, 8'h5A);

    // 5: reload together with a core write; writes ignored while loading
    adr = 8'h10; memwrite = 1'b1; writedata = 8'h77; reload = 1'b1; tick();
    reload = 1'b0; writedata = 8'hEE;
    probe("t5_reload", 8'h00, 1'b1, 1'b1, 1'b1);
    tick();
    memwrite = 1'b0;
    send(8'd1); send(8'h5C);
    rd("t5_a10", 8'h10, 8'h77);
    rd("t5_a0", 8'h00, 8'h5C);

    // 4: header 0 -> full 256-byte image
    reload = 1'b1; tick(); reload = 1'b0;
    send(8'd0);
    for (int i = 0; i < 255; i++) begin
      b = 8'(i) ^ 8'hFF;
      send(b);
    end
    in_valid = 1'b1; in_data = 8'h00;
    probe("t4_before_last", 8'h00, 1'b1, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i) ^ 8'hFF;
      rd("t4_image", 8'(i), b);
    end

    // 6: reset mid-load, partial bytes persist
    reload = 1'b1; tick(); reload = 1'b0;
    send(8'd4); send(8'h01); send(8'h02);
    reset = 1'b1;
    #1;
    probe("t6_reset", 8'h00, 1'b1, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    send(8'd1); send(8'hEE);
    rd("t6_a0", 8'd0, 8'hEE);
    rd("t6_a1_partial", 8'd1, 8'h02);
    rd("t6_a2_old", 8'd2, 8'hFD);
    rd("t6_a3_old", 8'd3, 8'hFC);

    tick();
    checks++;
    if (eq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
